sram_1rw_arbiter: RTL and testbench

- Controller that shares one single-port (1RW) SRAM macro port between two requesters, A and B. The macro is 32-bit × 2048 words, with active-low chip select and write enable, and samples its inputs at posedge.
- Provides per-requester valid/ready request channels, round-robin arbitration and in-order read responses.
- Includes an optional post-reset clear engine that zero-fills the array before service starts.
- Sits between client logic and the SRAM macro instance; it is the only driver of the macro pins.

---
 rtl/sram_1rw_arbiter_if.sv | 32 +++
 rtl/sram_1rw_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_1rw_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_1rw_arbiter_if.sv
// Requester-side bus of the shared 1RW SRAM arbiter.
// Holds two valid/ready command channels and the shared read-response path.
interface sram_1rw_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 11
);
  logic                  a_valid;
  logic                  a_ready;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_rsp_valid;
  logic                  b_valid;
  logic                  b_ready;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    output b_valid, b_we, b_addr, b_wdata,
    input  a_ready, a_rsp_valid, b_ready, b_rsp_valid, rsp_rdata
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    input  b_valid, b_we, b_addr, b_wdata,
    output a_ready, a_rsp_valid, b_ready, b_rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_1rw_arbiter.sv
// Round-robin arbiter sharing one 1RW SRAM macro port between requesters A and B,
// with fixed-latency in-order read responses and an optional post-reset zero-fill.
module sram_1rw_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  sram_1rw_arbiter_if.slave     bus,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  // One extra bit so the counter can never wrap back onto word 0.
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      clr_cnt;
  logic                  clr_last;
  logic                  prio_b;
  logic                  grant_a;
  logic                  grant_b;
  logic                  accept;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  s1_vld, s1_id, s2_vld, s2_id;
  logic                  a_rsp_q, b_rsp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign clr_last = (clr_cnt == CNT_W'(RAM_DEPTH - 1));

  // State register
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nxt;
  end

  // Next state: CLEAR ends once the final word's write has been registered
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_last) state_nxt = ST_RUN;
  end

  // Grant and command select; the pointer only breaks ties
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    if (state == ST_RUN) begin
      if (bus.a_valid && (!bus.b_valid || !prio_b)) grant_a = 1'b1;
      else if (bus.b_valid)                          grant_b = 1'b1;
    end
    accept    = grant_a | grant_b;
    acc_we    = grant_a ? bus.a_we    : bus.b_we;
    acc_addr  = grant_a ? bus.a_addr  : bus.b_addr;
    acc_wdata = grant_a ? bus.a_wdata : bus.b_wdata;
  end

  assign bus.a_ready     = grant_a;
  assign bus.b_ready     = grant_b;
  assign bus.a_rsp_valid = a_rsp_q;
  assign bus.b_rsp_valid = b_rsp_q;
  assign bus.rsp_rdata   = rdata_q;
  assign init_done       = (state == ST_RUN);

  // Priority pointer flips only when the favoured requester is served
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      prio_b  <= 1'b0;
      clr_cnt <= '0;
    end else begin
      if ((grant_a && !prio_b) || (grant_b && prio_b)) prio_b <= ~prio_b;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + CNT_W'(1);
    end
  end

  // Macro pins; write enable, address and data hold while idle
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else if (state == ST_CLEAR) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= 1'b0;
      sram_addr0 <= clr_cnt[ADDR_WIDTH-1:0];
      sram_din0  <= '0;
    end else if (accept) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= ~acc_we;
      sram_addr0 <= acc_addr;
      sram_din0  <= acc_wdata;
    end else begin
      sram_csb0  <= 1'b1;
    end
  end

  // Read tracking: issue, macro sample, then capture dout into the response
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_id   <= 1'b0;
      s2_vld  <= 1'b0;
      s2_id   <= 1'b0;
      a_rsp_q <= 1'b0;
      b_rsp_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      s1_vld  <= accept && !acc_we;
      s1_id   <= grant_b;
      s2_vld  <= s1_vld;
      s2_id   <= s1_id;
      a_rsp_q <= s2_vld && !s2_id;
      b_rsp_q <= s2_vld && s2_id;
      if (s2_vld) rdata_q <= sram_dout0;
    end
  end

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Directed bench for sram_1rw_arbiter: a behavioural 1RW macro on the main instance,
// plus a second instance built without the post-reset clear.
module tb_sram_1rw_arbiter;

  logic        clk0 = 1'b0;
  logic        rst_n;
  logic        rst2_n;
  logic        init_done, init_done2;
  logic        sram_csb0, sram_web0, sram2_csb0, sram2_web0;
  logic [10:0] sram_addr0, sram2_addr0;
  logic [31:0] sram_din0, sram_dout0, sram2_din0;
  logic [31:0] sram2_dout0 = 32'h0;
  logic [31:0] mem [2048];

  int n_vec = 0;
  int n_err = 0;

  sram_1rw_arbiter_if bus ();
  sram_1rw_arbiter_if bus2 ();

  sram_1rw_arbiter u_dut (
    .clk0(clk0), .rst_n(rst_n), .bus(bus), .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  sram_1rw_arbiter #(.CLEAR_ON_RESET(1'b0)) u_nc (
    .clk0(clk0), .rst_n(rst2_n), .bus(bus2), .init_done(init_done2),
    .sram_csb0(sram2_csb0), .sram_web0(sram2_web0), .sram_addr0(sram2_addr0),
    .sram_din0(sram2_din0), .sram_dout0(sram2_dout0)
  );

  always #5 clk0 = ~clk0;

  // Behavioural macro: samples pins at posedge, registered read data
  always @(posedge clk0) begin
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0      <= mem[sram_addr0];
    end
  end

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic test_reset();
    bus.a_valid = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h0; bus.a_wdata = 32'h0;
    repeat (3) step();
    #1;
    n_vec++;
    if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1) begin
      n_err++; $display("FAIL reset_ctl: csb=%b web=%b want 1 1", sram_csb0, sram_web0);
    end
    n_vec++;
    if (sram_addr0 !== 11'h0 || sram_din0 !== 32'h0) begin
      n_err++; $display("FAIL reset_pins: addr=%h din=%h want 0 0", sram_addr0, sram_din0);
    end
    n_vec++;
    if (bus.a_rsp_valid !== 1'b0 || bus.b_rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rsp: a=%b b=%b rdata=%h want 0 0 0",
                        bus.a_rsp_valid, bus.b_rsp_valid, bus.rsp_rdata);
    end
    n_vec++;
    if (init_done !== 1'b0 || bus.a_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: init_done=%b a_ready=%b want 0 0", init_done, bus.a_ready);
    end
    bus.a_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_clear();
    int n = 0;
    int bad = 0;
    bit done = 1'b0;
    for (int c = 0; c < 2100 && !done; c++) begin
      step();
      if (sram_csb0 === 1'b0 && sram_web0 === 1'b0) begin
        if (sram_addr0 !== n[10:0] || sram_din0 !== 32'h0) bad++;
        n++;
      end
      if (init_done === 1'b1) done = 1'b1;
    end
    n_vec++;
    if (!done) begin n_err++; $display("FAIL clear_timeout: init_done=%b want 1", init_done); end
    n_vec++;
    if (n != 2048) begin n_err++; $display("FAIL clear_count: got %0d want 2048", n); end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL clear_addr_data: %0d bad writes want 0", bad); end
    n_vec++;
    if (sram_addr0 !== 11'h7FF) begin
      n_err++; $display("FAIL clear_last: addr=%h want 7ff when init_done rises", sram_addr0);
    end
    step();
    n_vec++;
    if (sram_csb0 !== 1'b1) begin n_err++; $display("FAIL clear_stop: csb=%b want 1", sram_csb0); end
    bus.a_valid = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h7FF;
    #1;
    n_vec++;
    if (bus.a_ready !== 1'b1) begin n_err++; $display("FAIL read_7ff_ready: got %b want 1", bus.a_ready); end
    step();
    bus.a_valid = 1'b0;
    step();
    step();
    n_vec++;
    if (bus.a_rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL read_7ff: rsp=%b rdata=%h want 1 00000000", bus.a_rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_write_read();
    bus.a_valid = 1'b1; bus.a_we = 1'b1; bus.a_addr = 11'h005; bus.a_wdata = 32'hDEADBEEF;
    #1;
    n_vec++;
    if (bus.a_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %b want 1", bus.a_ready); end
    step();
    bus.a_we = 1'b0;
    #1;
    n_vec++;
    if (bus.a_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready: got %b want 1", bus.a_ready); end
    step();
    bus.a_valid = 1'b0;
    step();
    n_vec++;
    if (bus.a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_early: rsp=%b want 0", bus.a_rsp_valid); end
    step();
    n_vec++;
    if (bus.a_rsp_valid !== 1'b1 || bus.b_rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rd_after_wr: a=%b b=%b rdata=%h want 1 0 deadbeef",
                        bus.a_rsp_valid, bus.b_rsp_valid, bus.rsp_rdata);
    end
    step();
    n_vec++;
    if (bus.a_rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rsp_pulse: rsp=%b rdata=%h want 0 deadbeef", bus.a_rsp_valid, bus.rsp_rdata);
    end
  endtask

  // Pointer enters pointing at B; a lone B grant moves it to A, the next lone B grant leaves it
  task automatic test_only_b();
    bus.b_valid = 1'b1; bus.b_we = 1'b1; bus.b_addr = 11'h010; bus.b_wdata = 32'h11111111;
    #1;
    n_vec++;
    if (bus.b_ready !== 1'b1) begin n_err++; $display("FAIL onlyb_setup: b_ready=%b want 1", bus.b_ready); end
    step();
    bus.b_addr = 11'h020; bus.b_wdata = 32'h22222222;
    #1;
    n_vec++;
    if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
      n_err++; $display("FAIL onlyb_grant: a=%b b=%b want 0 1", bus.a_ready, bus.b_ready);
    end
    step();
    bus.a_valid = 1'b1; bus.a_we = 1'b1; bus.a_addr = 11'h030; bus.a_wdata = 32'h33333333;
    bus.b_addr = 11'h040; bus.b_wdata = 32'h44444444;
    #1;
    n_vec++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      n_err++; $display("FAIL onlyb_then_both: a=%b b=%b want 1 0", bus.a_ready, bus.b_ready);
    end
    step();
    bus.a_valid = 1'b0;
    #1;
    n_vec++;
    if (bus.b_ready !== 1'b1) begin n_err++; $display("FAIL onlyb_waiting_b: b_ready=%b want 1", bus.b_ready); end
    step();
    bus.b_valid = 1'b0;
  endtask

  task automatic test_alternation();
    bus.a_we = 1'b0; bus.a_addr = 11'h010;
    bus.b_we = 1'b0; bus.b_addr = 11'h020;
    for (int i = 0; i < 6; i++) begin
      bus.a_valid = (i < 4);
      bus.b_valid = (i < 4);
      #1;
      if (i < 4) begin
        n_vec++;
        if (bus.a_ready !== (i % 2 == 0) || bus.b_ready !== (i % 2 == 1)) begin
          n_err++; $display("FAIL alt_grant%0d: a=%b b=%b want %b %b", i, bus.a_ready, bus.b_ready,
                            (i % 2 == 0), (i % 2 == 1));
        end
      end
      step();
      if (i >= 2) begin
        n_vec++;
        if (bus.a_rsp_valid !== ((i - 2) % 2 == 0) || bus.b_rsp_valid !== ((i - 2) % 2 == 1) ||
            bus.rsp_rdata !== (((i - 2) % 2 == 0) ? 32'h11111111 : 32'h22222222)) begin
          n_err++; $display("FAIL alt_rsp%0d: a=%b b=%b rdata=%h", i - 2,
                            bus.a_rsp_valid, bus.b_rsp_valid, bus.rsp_rdata);
        end
      end else begin
        n_vec++;
        if (bus.a_rsp_valid !== 1'b0 || bus.b_rsp_valid !== 1'b0) begin
          n_err++; $display("FAIL alt_early%0d: a=%b b=%b want 0 0", i, bus.a_rsp_valid, bus.b_rsp_valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    bit done = 1'b0;
    bus.a_valid = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h005;
    step();
    step();
    bus.a_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1) begin
      n_err++; $display("FAIL async_reset: csb=%b web=%b want 1 1", sram_csb0, sram_web0);
    end
    bus.a_valid = 1'b1;
    repeat (4) begin
      step();
      if (bus.a_rsp_valid !== 1'b0 || bus.b_rsp_valid !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== 11'h0) begin
      n_err++; $display("FAIL clear_restart: csb=%b web=%b addr=%h want 0 0 000", sram_csb0, sram_web0, sram_addr0);
    end
    n_vec++;
    if (bus.a_ready !== 1'b0) begin n_err++; $display("FAIL clear_hold: a_ready=%b want 0", bus.a_ready); end
    for (int c = 0; c < 2100 && !done; c++) begin
      if (bus.a_rsp_valid !== 1'b0 || bus.b_rsp_valid !== 1'b0) bad++;
      if (init_done === 1'b1) done = 1'b1;
      else step();
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL reset_drop: %0d stray responses want 0", bad); end
    n_vec++;
    if (!done || bus.a_ready !== 1'b1) begin
      n_err++; $display("FAIL clear_wait_grant: init_done=%b a_ready=%b want 1 1", init_done, bus.a_ready);
    end
    step();
    bus.a_valid = 1'b0;
    step();
    step();
    n_vec++;
    if (bus.a_rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL reclear_read: rsp=%b rdata=%h want 1 00000000", bus.a_rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_no_clear();
    bus2.a_valid = 1'b1; bus2.a_we = 1'b1; bus2.a_addr = 11'h123; bus2.a_wdata = 32'hCAFEF00D;
    step();
    n_vec++;
    if (sram2_csb0 !== 1'b1) begin n_err++; $display("FAIL nc_in_reset: csb=%b want 1", sram2_csb0); end
    rst2_n = 1'b1;
    #1;
    n_vec++;
    if (init_done2 !== 1'b1) begin n_err++; $display("FAIL nc_init_done: got %b want 1", init_done2); end
    step();
    n_vec++;
    if (sram2_csb0 !== 1'b0 || sram2_web0 !== 1'b0 || sram2_addr0 !== 11'h123 || sram2_din0 !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL nc_first_accept: csb=%b web=%b addr=%h din=%h want 0 0 123 cafef00d",
                        sram2_csb0, sram2_web0, sram2_addr0, sram2_din0);
    end
    bus2.a_valid = 1'b0;
    step();
    n_vec++;
    if (sram2_csb0 !== 1'b1 || sram2_addr0 !== 11'h123) begin
      n_err++; $display("FAIL nc_idle: csb=%b addr=%h want 1 123", sram2_csb0, sram2_addr0);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bus.a_valid  = 1'b0; bus.a_we  = 1'b0; bus.a_addr  = '0; bus.a_wdata  = '0;
    bus.b_valid  = 1'b0; bus.b_we  = 1'b0; bus.b_addr  = '0; bus.b_wdata  = '0;
    bus2.a_valid = 1'b0; bus2.a_we = 1'b0; bus2.a_addr = '0; bus2.a_wdata = '0;
    bus2.b_valid = 1'b0; bus2.b_we = 1'b0; bus2.b_addr = '0; bus2.b_wdata = '0;
    test_reset();
    test_clear();
    test_write_read();
    test_only_b();
    test_alternation();
    test_reset_mid();
    test_no_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
